// File: rtl/riscv_pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// State encoding, sequence counter width, control bundle.
package riscv_pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } ctrl_state_e;

    // Wide enough for MDU_LATENCY-2 (max 14) and FLUSH_CYCLES-1.
    localparam int SEQ_W = 4;

    // en/clr bit order: [3]=IF/ID [2]=ID/EX [1]=EX/MEM [0]=MEM/WB
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] clr;
        logic       mdu_done;
    } ctrl_out_t;

    localparam logic [3:0] BANK_ALL   = 4'b1111;
    localparam logic [3:0] BANK_NONE  = 4'b0000;
    localparam logic [3:0] BANK_IFID  = 4'b1000;
    localparam logic [3:0] BANK_IDEX  = 4'b0100;
    localparam logic [3:0] BANK_EXMEM = 4'b0010;
    localparam logic [3:0] BANK_MEMWB = 4'b0001;

endpackage

// File: rtl/riscv_pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator between the ID sources
// and the destination of a load sitting in EX.
module riscv_hazard_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_ex_valid,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    output logic       o_load_use
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a dependency
    assign rd_live = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0);
    assign rs1_hit = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign rs2_hit = i_id_rs2_used & (i_id_rs2 == i_ex_rd);

    assign o_load_use = rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Drives bank enables/clears; counts stalled cycles.
module riscv_pipeline_ctrl
    import riscv_pipeline_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY  = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic             i_ex_valid,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_is_load,
    input  logic             i_ex_mdu,
    input  logic             i_ex_redirect,
    input  logic             i_trap,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_pc_en,
    output logic             o_en_ifid,
    output logic             o_en_idex,
    output logic             o_en_exmem,
    output logic             o_en_memwb,
    output logic             o_clr_ifid,
    output logic             o_clr_idex,
    output logic             o_clr_exmem,
    output logic             o_clr_memwb,
    output logic             o_mdu_done,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [SEQ_W-1:0] MDU_LD =
        SEQ_W'(MDU_LATENCY - 2);
    localparam logic [SEQ_W-1:0] FLUSH_LD =
        (FLUSH_CYCLES > 0) ? SEQ_W'(FLUSH_CYCLES - 1) : '0;
    localparam ctrl_state_e REDIR_ST =
        (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;

    ctrl_state_e      state;
    ctrl_state_e      nxt_state;
    logic [SEQ_W-1:0] seq;
    logic [SEQ_W-1:0] nxt_seq;
    logic [CNT_W-1:0] stall_cnt;
    ctrl_out_t        ctl;
    logic             load_use;
    logic             mem_stall;
    logic             mdu_start;

    riscv_hazard_detect u_hazard (
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .i_ex_valid    (i_ex_valid),
        .i_ex_rd       (i_ex_rd),
        .i_ex_is_load  (i_ex_is_load),
        .o_load_use    (load_use)
    );

    assign mem_stall = i_mem_req & ~i_mem_ack;
    assign mdu_start = i_ex_valid & i_ex_mdu;

    // Hazard priority resolution, bank controls and next state
    always_comb begin
        nxt_state    = state;
        nxt_seq      = seq;
        ctl.pc_en    = 1'b1;
        ctl.en       = BANK_ALL;
        ctl.clr      = BANK_NONE;
        ctl.mdu_done = 1'b0;
        if (i_rst) begin
            ctl.pc_en = 1'b0;
            ctl.en    = BANK_NONE;
            ctl.clr   = BANK_ALL;
            nxt_state = ST_RUN;
            nxt_seq   = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (i_trap) begin
                        ctl.clr   = BANK_IFID | BANK_IDEX | BANK_EXMEM;
                        nxt_state = REDIR_ST;
                        nxt_seq   = FLUSH_LD;
                    end else if (mem_stall) begin
                        ctl.pc_en = 1'b0;
                        ctl.en    = BANK_MEMWB;
                        ctl.clr   = BANK_MEMWB;
                        nxt_state = ST_MEM_WAIT;
                    end else if (mdu_start) begin
                        ctl.pc_en = 1'b0;
                        ctl.en    = BANK_MEMWB;
                        ctl.clr   = BANK_MEMWB;
                        nxt_state = ST_MDU;
                        nxt_seq   = MDU_LD;
                    end else if (i_ex_redirect) begin
                        ctl.clr   = BANK_IFID | BANK_IDEX;
                        nxt_state = REDIR_ST;
                        nxt_seq   = FLUSH_LD;
                    end else if (load_use) begin
                        ctl.pc_en = 1'b0;
                        ctl.en    = BANK_ALL & ~BANK_IFID;
                        ctl.clr   = BANK_IDEX;
                    end
                end
                ST_MDU: begin
                    if (seq == '0) begin
                        ctl.mdu_done = 1'b1;
                        nxt_state    = ST_RUN;
                    end else begin
                        ctl.pc_en = 1'b0;
                        ctl.en    = BANK_MEMWB;
                        ctl.clr   = BANK_MEMWB;
                        nxt_seq   = seq - 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        nxt_state = ST_RUN;
                    end else begin
                        ctl.pc_en = 1'b0;
                        ctl.en    = BANK_MEMWB;
                        ctl.clr   = BANK_MEMWB;
                    end
                end
                ST_FLUSH: begin
                    // wrong-path redirects are dropped here
                    if (i_trap) begin
                        ctl.clr = BANK_IFID | BANK_IDEX | BANK_EXMEM;
                        nxt_seq = FLUSH_LD;
                    end else if (seq == '0) begin
                        ctl.clr   = BANK_IFID;
                        nxt_state = ST_RUN;
                    end else begin
                        ctl.clr = BANK_IFID;
                        nxt_seq = seq - 1'b1;
                    end
                end
            endcase
        end
    end

    // State, sequence counter and saturating stall counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_RUN;
            seq       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= nxt_state;
            seq   <= nxt_seq;
            if (!ctl.pc_en && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign o_pc_en     = ctl.pc_en;
    assign o_en_ifid   = ctl.en[3];
    assign o_en_idex   = ctl.en[2];
    assign o_en_exmem  = ctl.en[1];
    assign o_en_memwb  = ctl.en[0];
    assign o_clr_ifid  = ctl.clr[3];
    assign o_clr_idex  = ctl.clr[2];
    assign o_clr_exmem = ctl.clr[1];
    assign o_clr_memwb = ctl.clr[0];
    assign o_mdu_done  = ctl.mdu_done;
    assign o_state     = state;
    assign o_stall_cnt = stall_cnt;

endmodule
